// File: rtl/inst_sram_resp.sv
// inst_sram_resp: instruction-memory responder with 1-cycle read-first access, loader port, window error capture and saturating counters
module inst_sram_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [31:0] FILL_WORD  = 32'h03400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_sram_en,
  input  logic [3:0]            inst_sram_wen,
  input  logic [31:0]           inst_sram_addr,
  input  logic [31:0]           inst_sram_wdata,
  output logic [31:0]           inst_sram_rdata,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_wdata,
  output logic                  err,
  output logic [31:0]           err_addr,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic in_win;
  assign off = inst_sram_addr - BASE_ADDR;
  assign in_win = off[31:DEPTH_LOG2+2] == '0;
  assign idx = off[DEPTH_LOG2+1:2];
  // loader write comes last so it overrides every lane of a colliding inst write
  always_ff @(posedge clk) begin
    if (!reset && inst_sram_en && in_win)
      for (int i = 0; i < 4; i++)
        if (inst_sram_wen[i]) mem[idx][8*i+:8] <= inst_sram_wdata[8*i+:8];
    if (ld_we) mem[ld_idx] <= ld_wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= '0;
      err <= 1'b0;
      err_addr <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (inst_sram_en) begin
      inst_sram_rdata <= in_win ? mem[idx] : FILL_WORD;
      if (inst_sram_wen == 4'h0) rd_cnt <= rd_cnt + {31'b0, ~&rd_cnt};
      else wr_cnt <= wr_cnt + {31'b0, ~&wr_cnt};
      if (!in_win) begin
        err <= 1'b1;
        if (!err) err_addr <= inst_sram_addr;
      end
    end
  end
endmodule

// File: tb/tb_inst_sram_resp.sv
// tb_inst_sram_resp: directed table, corner sequences and randomized run against a behavioural model
module tb_inst_sram_resp;
  localparam logic [31:0] BASE = 32'h1c000000;
  localparam logic [31:0] FILL = 32'h03400000;
  localparam logic [31:0] WIN_BYTES = 32'h00040000;
  logic clk = 1'b0;
  logic reset, en, ld_we, err;
  logic [3:0] wen;
  logic [31:0] addr, wdata, rdata, ld_wdata, err_addr, rd_cnt, wr_cnt;
  logic [15:0] ld_idx;
  int total = 0;
  int bad = 0;
  logic [31:0] m [int];
  logic [31:0] m_rdata, m_err_addr, m_rdc, m_wrc;
  logic m_err;
  inst_sram_resp dut (
    .clk(clk), .reset(reset), .inst_sram_en(en), .inst_sram_wen(wen),
    .inst_sram_addr(addr), .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_wdata(ld_wdata), .err(err),
    .err_addr(err_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic lwe, input logic [15:0] li, input logic [31:0] ld);
    logic [31:0] o;
    int ix;
    reset = r; en = e; wen = w; addr = a; wdata = d; ld_we = lwe; ld_idx = li; ld_wdata = ld;
    o = a - BASE;
    ix = int'(o >> 2);
    if (r) begin
      m_rdata = 0; m_err = 0; m_err_addr = 0; m_rdc = 0; m_wrc = 0;
    end else if (e) begin
      if (o < WIN_BYTES) begin
        m_rdata = m[ix];
        for (int b = 0; b < 4; b++) if (w[b]) m[ix][8*b+:8] = d[8*b+:8];
      end else begin
        m_rdata = FILL;
        if (!m_err) m_err_addr = a;
        m_err = 1;
      end
      if (w == 0) m_rdc = (m_rdc == 32'hffffffff) ? m_rdc : m_rdc + 1;
      else m_wrc = (m_wrc == 32'hffffffff) ? m_wrc : m_wrc + 1;
    end
    if (lwe) m[int'(li)] = ld;
    @(posedge clk);
    #1;
    chk("rdata", rdata, m_rdata);
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("err_addr", err_addr, m_err_addr);
    chk("rd_cnt", rd_cnt, m_rdc);
    chk("wr_cnt", wr_cnt, m_wrc);
  endtask
  typedef struct {
    logic en;
    logic [3:0] wen;
    logic [31:0] addr, wdata, rdata, rdc;
  } vec_t;
  vec_t tbl [13];
  initial begin
    logic [31:0] a;
    tbl[0]  = '{1, 4'h0, 32'h1c000000, 0, 32'h11111111, 1};
    tbl[1]  = '{1, 4'h0, 32'h1c000004, 0, 32'h22222222, 2};
    tbl[2]  = '{1, 4'h0, 32'h1c00000c, 0, 32'h44444444, 3};
    tbl[3]  = '{1, 4'h0, 32'h1c000004, 0, 32'h22222222, 4};
    for (int i = 4; i < 9; i++) tbl[i] = '{0, 4'h0, 32'h1c00000c, 0, 32'h22222222, 4};
    tbl[9]  = '{1, 4'h5, 32'h1c000008, 32'haabbccdd, 32'h33333333, 4};
    tbl[10] = '{1, 4'h0, 32'h1c000008, 0, 32'h33bb33dd, 5};
    tbl[11] = '{1, 4'h0, 32'h1bfffffc, 0, FILL, 6};
    tbl[12] = '{1, 4'h0, 32'h1c040000, 0, FILL, 7};
    @(posedge clk);
    #1;
    // preload under reset, with a request on the bus that must be ignored
    for (int i = 0; i < 64; i++)
      step(1, 1, 4'hf, BASE, 32'hdeadbeef, 1, 16'(i),
           i == 0 ? 32'h11111111 : i == 1 ? 32'h22222222 : i == 2 ? 32'h33333333 :
           i == 3 ? 32'h44444444 : $urandom);
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_rdata", rdata, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, 0, 0, 0);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdata);
      chk($sformatf("tbl%0d_rd_cnt", i), rd_cnt, tbl[i].rdc);
    end
    chk("tbl_err", {31'b0, err}, 1);
    chk("tbl_err_addr", err_addr, 32'h1bfffffc);
    chk("tbl_wr_cnt", wr_cnt, 1);
    // loader and inst write collide on idx 2
    step(0, 1, 4'hf, 32'h1c000008, 32'h0, 1, 16'd2, 32'h5a5a5a5a);
    chk("collide_readfirst", rdata, 32'h33bb33dd);
    step(0, 1, 4'h0, 32'h1c00000a, 0, 0, 0, 0);
    chk("collide_reread", rdata, 32'h5a5a5a5a);
    // later out-of-window request must not move err_addr
    step(0, 1, 4'h3, 32'h20000000, 32'h12345678, 0, 0, 0);
    chk("err_addr_sticky", err_addr, 32'h1bfffffc);
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(7) == 0)
          ? (($urandom_range(1) == 0) ? BASE - 32'(4 * $urandom_range(1, 8)) : BASE + WIN_BYTES + 32'(4 * $urandom_range(0, 8)))
          : BASE + 32'(4 * $urandom_range(63)) + 32'($urandom_range(3));
      step($urandom_range(49) == 0, $urandom_range(3) != 0,
           $urandom_range(1) == 0 ? 4'h0 : 4'($urandom), a, $urandom,
           $urandom_range(5) == 0, 16'($urandom_range(63)), $urandom);
    end
    force dut.rd_cnt = 32'hfffffffe;
    #1;
    release dut.rd_cnt;
    m_rdc = 32'hfffffffe;
    step(0, 1, 4'h0, BASE, 0, 0, 0, 0);
    chk("sat_reach", rd_cnt, 32'hffffffff);
    step(0, 1, 4'h0, BASE + 4, 0, 0, 0, 0);
    chk("sat_hold", rd_cnt, 32'hffffffff);
    step(0, 1, 4'h0, 32'h00000000, 0, 0, 0, 0);
    chk("sat_hold_oow", rd_cnt, 32'hffffffff);
    step(1, 1, 4'h0, BASE + 8, 0, 0, 0, 0);
    chk("midreset_rdata", rdata, 0);
    chk("midreset_rd_cnt", rd_cnt, 0);
    chk("midreset_err", {31'b0, err}, 0);
    step(0, 0, 4'h0, BASE, 0, 0, 0, 0);
    chk("post_reset_idle", rdata, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
